// File: rtl/router_pkg.sv
// Shared types for the router egress arbiter: FSM encoding, header field positions, skid entry layout.
// No logic here; the port increment helper wraps modulo NUM_PORTS.
package router_pkg;

    localparam int NUM_PORTS   = 3;
    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        HWAIT,
        BODY,
        DRAIN
    } arb_state_t;

    typedef struct packed {
        logic [7:0] dat;
        logic       sop;
        logic       eop;
        logic [1:0] port;
    } skid_entry_t;

    localparam int SKID_W = $bits(skid_entry_t);

    function automatic logic [1:0] port_inc(input logic [1:0] p);
        return (p == 2'(NUM_PORTS - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Small generic circular FIFO with occupancy count, used as the egress skid buffer.
// Latency: written entry is visible at the head the cycle after the write.
// Backpressure: a write is dropped only if full with no read that cycle; push+pop on full is allowed.
module router_skid_buf #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CNT_W-1:0] count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_rd;
    logic             do_wr;

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_rd = rd_rdy && (cnt != '0);
    assign do_wr = wr_vld && ((cnt != CNT_W'(DEPTH)) || do_rd);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_vld = (cnt != '0);
    assign rd_dat = mem[rd_ptr];
    assign count  = cnt;

endmodule

// File: rtl/router_out_arbiter.sv
// Output-side read scheduler: round-robin per-packet grant over three router FIFOs onto one egress stream.
// Latency: header read issued in cycle N reaches m_data with m_sop in cycle N+2 (registered via skid buffer).
// Backpressure: reads throttle on skid occupancy plus in-flight read; m_ready low freezes the head and halts reads.
module router_out_arbiter
    import router_pkg::*;
#(
    parameter int SKID_DEPTH = 2,
    parameter int STALL_MAX  = 64
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sop,
    output logic       m_eop,
    output logic [1:0] m_port,
    output logic       busy,
    output logic       abort_err
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    arb_state_t       state_q, state_d;
    logic [1:0]       grant_q;
    logic [1:0]       rr_ptr_q;
    logic [8:0]       remaining_q;
    logic [7:0]       stall_cnt_q;
    logic             inflight_q;
    logic             inflight_sop_q;
    logic             inflight_eop_q;
    logic [1:0]       inflight_port_q;

    logic [2:0]       vld_vec;
    logic             vld_g;
    logic [7:0]       data_g;
    logic [1:0]       cand1, cand2, pick;
    logic             pick_vld;
    logic             pop;
    logic             room;
    logic [OCC_W-1:0] occ_proj;
    logic             rd_issue;
    logic             abort_now;
    logic [CNT_W-1:0] skid_cnt;
    skid_entry_t      push_e;
    skid_entry_t      head_e;

    function automatic logic port_req(input logic [2:0] v, input logic [1:0] p);
        case (p)
            2'd0:    return v[0];
            2'd1:    return v[1];
            default: return v[2];
        endcase
    endfunction

    assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};

    always_comb begin
        vld_g = port_req(vld_vec, grant_q);
        case (inflight_port_q)
            2'd0:    data_g = data_out_0;
            2'd1:    data_g = data_out_1;
            default: data_g = data_out_2;
        endcase
    end

    // Scan rr_ptr, rr_ptr+1, rr_ptr+2 so the last-served port is considered only when nobody else asks.
    always_comb begin
        cand1    = port_inc(rr_ptr_q);
        cand2    = port_inc(cand1);
        pick     = rr_ptr_q;
        pick_vld = 1'b1;
        if (port_req(vld_vec, rr_ptr_q)) begin
            pick = rr_ptr_q;
        end else if (port_req(vld_vec, cand1)) begin
            pick = cand1;
        end else if (port_req(vld_vec, cand2)) begin
            pick = cand2;
        end else begin
            pick_vld = 1'b0;
        end
    end

    // A read is allowed only if its byte is guaranteed a slot when it lands next cycle.
    assign pop      = m_valid && m_ready;
    assign occ_proj = OCC_W'(skid_cnt) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign room     = (occ_proj < OCC_W'(SKID_DEPTH));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_issue  = 1'b0;
        abort_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (vld_g && room) begin
                    rd_issue = 1'b1;
                    state_d  = HWAIT;
                end
            end
            HWAIT: begin
                state_d = BODY;
            end
            BODY: begin
                if (stall_cnt_q == 8'(STALL_MAX)) begin
                    abort_now = 1'b1;
                    state_d   = IDLE;
                end else if (vld_g && room) begin
                    rd_issue = 1'b1;
                    if (remaining_q == 9'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            grant_q         <= 2'd0;
            rr_ptr_q        <= 2'd0;
            remaining_q     <= 9'd0;
            stall_cnt_q     <= 8'd0;
            inflight_q      <= 1'b0;
            inflight_sop_q  <= 1'b0;
            inflight_eop_q  <= 1'b0;
            inflight_port_q <= 2'd0;
            abort_err       <= 1'b0;
        end else begin
            if (state_q == IDLE && pick_vld) begin
                grant_q <= pick;
            end
            if (state_q == DRAIN || abort_now) begin
                rr_ptr_q <= port_inc(grant_q);
            end

            inflight_q <= rd_issue;
            if (rd_issue) begin
                inflight_sop_q  <= (state_q == HDR);
                inflight_eop_q  <= (state_q == BODY) && (remaining_q == 9'd1);
                inflight_port_q <= grant_q;
            end

            // Payload plus parity still to be read once the header has landed.
            if (state_q == HWAIT) begin
                remaining_q <= 9'(data_g[HDR_LEN_MSB:HDR_LEN_LSB]) + 9'd1;
            end else if (state_q == BODY && rd_issue) begin
                remaining_q <= remaining_q - 9'd1;
            end

            if (state_q != BODY || rd_issue) begin
                stall_cnt_q <= 8'd0;
            end else if (!vld_g) begin
                stall_cnt_q <= stall_cnt_q + 8'd1;
            end

            abort_err <= abort_now;
        end
    end

    assign read_enb_0 = rd_issue && (grant_q == 2'd0);
    assign read_enb_1 = rd_issue && (grant_q == 2'd1);
    assign read_enb_2 = rd_issue && (grant_q == 2'd2);
    assign busy       = (state_q != IDLE);

    assign push_e = '{dat: data_g, sop: inflight_sop_q, eop: inflight_eop_q, port: inflight_port_q};

    router_skid_buf #(
        .WIDTH (SKID_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clock  (clock),
        .resetn (resetn),
        .wr_vld (inflight_q),
        .wr_dat (push_e),
        .rd_rdy (m_ready),
        .rd_vld (m_valid),
        .rd_dat (head_e),
        .count  (skid_cnt)
    );

    assign m_data = m_valid ? head_e.dat  : 8'd0;
    assign m_sop  = m_valid && head_e.sop;
    assign m_eop  = m_valid && head_e.eop;
    assign m_port = m_valid ? head_e.port : 2'd0;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Bench for router_out_arbiter: FIFO models feed the arbiter, a scoreboard checks every egress byte in order.
module tb_router_out_arbiter;

    localparam int SKID_DEPTH = 2;
    localparam int STALL_MAX  = 64;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       vld_out_0 = 1'b0, vld_out_1 = 1'b0, vld_out_2 = 1'b0;
    logic [7:0] data_out_0 = '0, data_out_1 = '0, data_out_2 = '0;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_sop, m_eop;
    logic [1:0] m_port;
    logic       busy, abort_err;

    always #5 clock = ~clock;

    router_out_arbiter #(.SKID_DEPTH(SKID_DEPTH), .STALL_MAX(STALL_MAX)) dut (
        .clock(clock), .resetn(resetn),
        .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop), .m_eop(m_eop),
        .m_port(m_port), .busy(busy), .abort_err(abort_err)
    );

    typedef struct packed {
        logic [7:0] dat;
        logic       sop;
        logic       eop;
        logic [1:0] port;
    } exp_t;

    typedef struct {
        int         port;
        logic [7:0] hdr;
        int         exp_bytes;
    } vec_t;

    exp_t       exp_q[$];
    logic [7:0] fq0[$], fq1[$], fq2[$];

    int checks = 0, passes = 0;
    int cyc = 0;
    int rd_tot0 = 0, rd_tot1 = 0, rd_tot2 = 0;
    int out_tot = 0, eop_tot = 0, abort_tot = 0, viol = 0;
    int abort_cyc = 0, last_rd0_cyc = 0;
    logic abort_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    // FIFO models: registered non-empty flag, read data one cycle after the strobe.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (read_enb_0 && fq0.size() != 0) data_out_0 <= fq0.pop_front();
        if (read_enb_1 && fq1.size() != 0) data_out_1 <= fq1.pop_front();
        if (read_enb_2 && fq2.size() != 0) data_out_2 <= fq2.pop_front();
        vld_out_0 <= (fq0.size() != 0);
        vld_out_1 <= (fq1.size() != 0);
        vld_out_2 <= (fq2.size() != 0);
    end

    always @(negedge clock) begin
        if (resetn) begin
            if (read_enb_0) begin rd_tot0++; last_rd0_cyc = cyc; end
            if (read_enb_1) rd_tot1++;
            if (read_enb_2) rd_tot2++;
            if (int'(read_enb_0) + int'(read_enb_1) + int'(read_enb_2) > 1) viol++;
            if ((read_enb_0 && !vld_out_0) || (read_enb_1 && !vld_out_1) || (read_enb_2 && !vld_out_2)) viol++;
            if (abort_err) begin abort_tot++; abort_cyc = cyc; abort_busy = busy; end
            if (m_valid && m_ready) begin
                out_tot++;
                if (m_eop) eop_tot++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL sb_unexpected: got byte %0h port %0d with none expected", m_data, m_port);
                end else begin
                    check("sb_byte", {m_data, m_sop, m_eop, m_port}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic load_pkt(input int port, input logic [7:0] hdr, input int keep);
        int total, n;
        logic [7:0] b, par;
        total = int'(hdr[7:2]) + 2;
        n     = (keep < 0 || keep > total) ? total : keep;
        par   = '0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) b = hdr;
            else if (i == total - 1) b = par;
            else b = 8'($urandom);
            par ^= b;
            case (port)
                0:       fq0.push_back(b);
                1:       fq1.push_back(b);
                default: fq2.push_back(b);
            endcase
            exp_q.push_back('{dat: b, sop: (i == 0), eop: (i == total - 1), port: 2'(port)});
        end
    endtask

    function automatic int get_rd(input int port);
        return (port == 0) ? rd_tot0 : (port == 1) ? rd_tot1 : rd_tot2;
    endfunction

    function automatic logic rd_now(input int port);
        return (port == 0) ? read_enb_0 : (port == 1) ? read_enb_1 : read_enb_2;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clock);
        while ((exp_q.size() != 0 || busy || m_valid) && n < budget) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n < budget) passes++;
        else $display("FAIL %s: drain timeout, %0d bytes still expected", name, exp_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   n, base_out, base_eop, base_rd, base_abort, rd_mid;
        logic l1, l2, s2, stable;
        logic [1:0] p2;
        logic [7:0] hold_dat;

        vecs[0] = '{1, 8'h0D, 5};
        vecs[1] = '{2, 8'h02, 2};
        vecs[2] = '{0, 8'hFC, 65};
        vecs[3] = '{1, 8'h05, 3};

        // All three FIFOs loaded before reset release: expect 0,1,2 in order.
        load_pkt(0, 8'h08, -1);
        load_pkt(1, 8'h09, -1);
        load_pkt(2, 8'h0A, -1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs", {read_enb_2, read_enb_1, read_enb_0, m_valid, m_data, m_sop, m_eop,
                                m_port, busy, abort_err}, '0);
        @(posedge clock); #1 resetn = 1'b1;
        wait_idle(200, "rr3_drain");

        // Pointer back at 0 after serving port 2: port 0 wins over port 2.
        @(posedge clock); #1;
        load_pkt(0, 8'h04, -1);
        load_pkt(2, 8'h06, -1);
        wait_idle(200, "rr_wrap_drain");

        for (int i = 0; i < 4; i++) begin
            base_out = out_tot; base_eop = eop_tot; base_rd = get_rd(vecs[i].port);
            @(posedge clock); #1;
            load_pkt(vecs[i].port, vecs[i].hdr, -1);
            n = 0;
            @(negedge clock);
            while (!rd_now(vecs[i].port) && n < 20) begin @(negedge clock); n++; end
            check("hdr_read_timeout", n < 20, 1'b1);
            @(negedge clock); l1 = m_valid;
            @(negedge clock); l2 = m_valid; s2 = m_sop; p2 = m_port;
            check("hdr_latency", {l1, l2, s2, p2}, {1'b0, 1'b1, 1'b1, 2'(vecs[i].port)});
            wait_idle(300, "vec_drain");
            check("vec_bytes", out_tot - base_out, vecs[i].exp_bytes);
            check("vec_reads", get_rd(vecs[i].port) - base_rd, vecs[i].exp_bytes);
            check("vec_eop", eop_tot - base_eop, 1);
        end

        // Sink stalls 10 cycles mid-packet.
        base_out = out_tot; base_eop = eop_tot;
        @(posedge clock); #1;
        load_pkt(0, 8'h28, -1);
        n = 0;
        while (out_tot - base_out < 3 && n < 50) begin @(negedge clock); n++; end
        check("bp_start_timeout", n < 50, 1'b1);
        @(posedge clock); #1 m_ready = 1'b0;
        repeat (3) @(negedge clock);
        rd_mid = rd_tot0; hold_dat = m_data; stable = m_valid;
        repeat (7) begin
            @(negedge clock);
            if (!m_valid || m_data !== hold_dat) stable = 1'b0;
        end
        check("bp_no_read", rd_tot0 - rd_mid, 0);
        check("bp_head_stable", stable, 1'b1);
        @(posedge clock); #1 m_ready = 1'b1;
        wait_idle(200, "bp_drain");
        check("bp_bytes", out_tot - base_out, 12);
        check("bp_eop", eop_tot - base_eop, 1);

        // FIFO0 runs dry after 4 of 8 bytes; FIFO1 waits and must follow the abort.
        base_out = out_tot; base_eop = eop_tot; base_abort = abort_tot;
        @(posedge clock); #1;
        load_pkt(0, 8'h18, 4);
        n = 0;
        @(negedge clock);
        while (!read_enb_0 && n < 20) begin @(negedge clock); n++; end
        check("stall_grant_timeout", n < 20, 1'b1);
        @(posedge clock); #1;
        load_pkt(1, 8'h05, -1);
        wait_idle(400, "stall_drain");
        check("stall_abort_pulses", abort_tot - base_abort, 1);
        check("stall_abort_window", (abort_cyc - last_rd0_cyc >= STALL_MAX) &&
                                    (abort_cyc - last_rd0_cyc <= STALL_MAX + 3), 1'b1);
        check("stall_busy_at_abort", abort_busy, 1'b0);
        check("stall_bytes", out_tot - base_out, 7);
        check("stall_eop", eop_tot - base_eop, 1);

        // Reset mid-body: everything drops at once, pointer returns to 0.
        base_out = out_tot;
        @(posedge clock); #1;
        load_pkt(1, 8'h51, -1);
        n = 0;
        while (out_tot - base_out < 5 && n < 50) begin @(negedge clock); n++; end
        check("rst_start_timeout", n < 50, 1'b1);
        @(posedge clock); #3 resetn = 1'b0;
        #1;
        check("rst_async_outputs", {read_enb_2, read_enb_1, read_enb_0, m_valid, m_data, m_sop, m_eop,
                                    m_port, busy, abort_err}, '0);
        exp_q.delete(); fq0.delete(); fq1.delete(); fq2.delete();
        load_pkt(1, 8'h09, -1);
        load_pkt(2, 8'h06, -1);
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        wait_idle(200, "rst_drain");

        check("protocol_violations", viol, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
